pc_fetch_f: RTL and testbench

PC_FETCH_F -- requirements
Module: pc_fetch_f

---
 rtl/pc_fetch_f_pkg.sv | 33 +++
 rtl/fd_reg.sv | 48 ++++
 rtl/pc_fetch_f.sv | 97 +++++++++
 tb/tb_pc_fetch_f.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_f_pkg.sv
// Shared CPU constants for the fetch stage: reset/exception PCs, redirect select
// encodings, fetch exception codes, the F/D register layout and the fetch FSM states.
package pc_fetch_f_pkg;

  localparam logic [31:0] ResetPc   = 32'h0000_3000;
  localparam logic [31:0] ExcVector = 32'h0000_4180;

  // npc_sel encodings driven by the decode stage
  localparam logic [1:0] NpcPc4    = 2'd0;
  localparam logic [1:0] NpcBranch = 2'd1;
  localparam logic [1:0] NpcJump   = 2'd2;
  localparam logic [1:0] NpcJr     = 2'd3;

  // Fetch-check exception codes
  localparam logic [4:0] ExcOk   = 5'd0;
  localparam logic [4:0] ExcAdEL = 5'd4;

  // Fetch FSM: StRefill means D holds a bubble, so D-stage redirects are meaningless
  typedef enum logic [0:0] {
    StRun    = 1'b0,
    StRefill = 1'b1
  } fetch_state_e;

  // Contents of the F/D pipeline register; all-zero is the flushed value
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc_code;
    logic        bd;
    logic        valid;
  } fd_t;

endpackage

// File: rtl/fd_reg.sv
// F/D pipeline register: flush (or reset) clears to a bubble, stall holds,
// otherwise captures the fetched instruction. Faulting fetches become a nop.
module fd_reg
  import pc_fetch_f_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] PC_F,
  input  logic [31:0] instr_F,
  input  logic [4:0]  ExcCode_F,
  input  logic        BD_F,
  output logic [31:0] PC_D,
  output logic [31:0] instr_D,
  output logic [4:0]  ExcCode_D,
  output logic        BD_D,
  output logic        valid_D
);

  fd_t fd_d, fd_q;

  // Build the value captured on a normal (non-stalled, non-flushed) edge
  always_comb begin
    fd_d          = '0;
    fd_d.pc       = PC_F;
    fd_d.instr    = (ExcCode_F != ExcOk) ? 32'h0 : instr_F;
    fd_d.exc_code = ExcCode_F;
    fd_d.bd       = BD_F;
    fd_d.valid    = 1'b1;
  end

  // Register update: reset/flush beat stall, stall beats load
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      fd_q <= '0;
    end else if (!stall) begin
      fd_q <= fd_d;
    end
  end

  assign PC_D      = fd_q.pc;
  assign instr_D   = fd_q.instr;
  assign ExcCode_D = fd_q.exc_code;
  assign BD_D      = fd_q.bd;
  assign valid_D   = fd_q.valid;

endmodule

// File: rtl/pc_fetch_f.sv
// Fetch stage: PC register, next-PC selection and the RUN/REFILL tracker.
// Priority for the next PC is exc_req > eret > stall > redirect > PC+4.
module pc_fetch_f
  import pc_fetch_f_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = ResetPc,
  parameter logic [31:0] EXC_VECTOR = ExcVector
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic        is_jump_D,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic [31:0] instr_F,
  input  logic [4:0]  ExcCode_F,
  output logic [31:0] PC,
  output logic [31:0] PC_D,
  output logic [31:0] instr_D,
  output logic [4:0]  ExcCode_D,
  output logic        BD_D,
  output logic        valid_D
);

  logic [31:0]  pc_d, pc_q;
  fetch_state_e state_d, state_q;
  logic         flush;
  logic         bd_f;

  // Next PC, next state and flush request
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    flush   = 1'b0;
    bd_f    = 1'b0;
    if (exc_req) begin
      pc_d    = EXC_VECTOR;
      state_d = StRefill;
      flush   = 1'b1;
    end else if (eret) begin
      // eret has no delay slot: the instruction at PC is discarded
      pc_d    = epc;
      state_d = StRefill;
      flush   = 1'b1;
    end else if (!stall) begin
      state_d = StRun;
      if (state_q == StRun) begin
        bd_f = is_jump_D;
        unique case (npc_sel)
          NpcPc4:    pc_d = pc_q + 32'd4;
          NpcBranch: pc_d = branch_target;
          NpcJump:   pc_d = jump_target;
          NpcJr:     pc_d = jr_target;
          default:   pc_d = pc_q + 32'd4;
        endcase
      end else begin
        // D holds a bubble, so its redirect and jump flag are stale
        pc_d = pc_q + 32'd4;
      end
    end
  end

  // PC and FSM state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      state_q <= StRun;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign PC = pc_q;

  fd_reg u_fd_reg (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .PC_F      (pc_q),
    .instr_F   (instr_F),
    .ExcCode_F (ExcCode_F),
    .BD_F      (bd_f),
    .PC_D      (PC_D),
    .instr_D   (instr_D),
    .ExcCode_D (ExcCode_D),
    .BD_D      (BD_D),
    .valid_D   (valid_D)
  );

endmodule

// File: tb/tb_pc_fetch_f.sv
// Self-checking bench for pc_fetch_f: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the fetch rules.
module tb_pc_fetch_f;

  localparam logic [31:0] RPC = 32'h0000_3000;
  localparam logic [31:0] EXV = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset, stall, is_jump_D, exc_req, eret;
  logic [1:0]  npc_sel;
  logic [31:0] branch_target, jump_target, jr_target, epc, instr_F;
  logic [4:0]  ExcCode_F;
  logic [31:0] PC, PC_D, instr_D;
  logic [4:0]  ExcCode_D;
  logic        BD_D, valid_D;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_refill;
  logic [31:0] m_pc_d, m_instr_d;
  logic [4:0]  m_exc_d;
  logic        m_bd_d, m_valid_d;

  always #5 clk = ~clk;

  pc_fetch_f #(
    .RESET_PC   (RPC),
    .EXC_VECTOR (EXV)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .npc_sel       (npc_sel),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .is_jump_D     (is_jump_D),
    .exc_req       (exc_req),
    .eret          (eret),
    .epc           (epc),
    .instr_F       (instr_F),
    .ExcCode_F     (ExcCode_F),
    .PC            (PC),
    .PC_D          (PC_D),
    .instr_D       (instr_D),
    .ExcCode_D     (ExcCode_D),
    .BD_D          (BD_D),
    .valid_D       (valid_D)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void flush_model();
    m_pc_d    = '0;
    m_instr_d = '0;
    m_exc_d   = '0;
    m_bd_d    = 1'b0;
    m_valid_d = 1'b0;
  endfunction

  // One rising edge of the fetch rules, applied to the current inputs
  function automatic void model_step();
    logic [31:0] tgt [4];
    if (!reset) begin
      m_pc = RPC; m_refill = 1'b0; flush_model();
    end else if (exc_req) begin
      m_pc = EXV; m_refill = 1'b1; flush_model();
    end else if (eret) begin
      m_pc = epc; m_refill = 1'b1; flush_model();
    end else if (!stall) begin
      m_pc_d    = m_pc;
      m_instr_d = (ExcCode_F != 5'd0) ? 32'h0 : instr_F;
      m_exc_d   = ExcCode_F;
      m_bd_d    = m_refill ? 1'b0 : is_jump_D;
      m_valid_d = 1'b1;
      tgt = '{m_pc + 32'd4, branch_target, jump_target, jr_target};
      m_pc = m_refill ? m_pc + 32'd4 : tgt[npc_sel];
      m_refill = 1'b0;
    end
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_val("PC", PC, m_pc);
    check_val("PC_D", PC_D, m_pc_d);
    check_val("instr_D", instr_D, m_instr_d);
    check_val("ExcCode_D", {27'd0, ExcCode_D}, {27'd0, m_exc_d});
    check_val("BD_D", {31'd0, BD_D}, {31'd0, m_bd_d});
    check_val("valid_D", {31'd0, valid_D}, {31'd0, m_valid_d});
  endtask

  task automatic idle();
    stall = 0; npc_sel = 2'd0; is_jump_D = 0; exc_req = 0; eret = 0;
    ExcCode_F = 5'd0; instr_F = $urandom;
  endtask

  initial begin
    reset = 0; branch_target = '0; jump_target = '0; jr_target = '0; epc = '0;
    m_pc = '0; m_refill = 1'b0; flush_model();
    idle();

    // Reset held two cycles
    step(); step();
    check_val("rst_pc", PC, 32'h3000);
    check_val("rst_valid", {31'd0, valid_D}, 32'd0);

    // Sequential fetch after release
    reset = 1; idle(); step();
    check_val("seq_pc0", PC, 32'h3004);
    check_val("seq_pcd0", PC_D, 32'h3000);
    check_val("seq_valid", {31'd0, valid_D}, 32'd1);
    idle(); step();
    idle(); step();
    check_val("seq_pc3", PC, 32'h300c);

    // Taken branch; 300c is the delay-slot holder in D
    idle(); is_jump_D = 1; npc_sel = 2'd1; branch_target = 32'h3040; step();
    check_val("br_pc", PC, 32'h3040);
    check_val("br_pcd", PC_D, 32'h300c);
    check_val("br_bd", {31'd0, BD_D}, 32'd1);

    // Go to 3010 and stall three cycles
    idle(); npc_sel = 2'd3; jr_target = 32'h3010; step();
    for (int i = 0; i < 3; i++) begin
      idle(); stall = 1; step();
    end
    check_val("stall_pc", PC, 32'h3010);
    idle(); step();
    check_val("resume_pc", PC, 32'h3014);

    // Exception together with stall at 3020
    idle(); npc_sel = 2'd2; jump_target = 32'h3020; step();
    idle(); exc_req = 1; stall = 1; step();
    check_val("exc_pc", PC, 32'h4180);
    check_val("exc_valid", {31'd0, valid_D}, 32'd0);
    idle(); is_jump_D = 1; npc_sel = 2'd1; step();  // redirect ignored in refill
    check_val("exc_pcd", PC_D, 32'h4180);
    check_val("refill_pc", PC, 32'h4184);

    // Misaligned jr target, then eret
    idle(); npc_sel = 2'd3; jr_target = 32'h3002; step();
    check_val("jr_pc", PC, 32'h3002);
    idle(); ExcCode_F = 5'd4; step();
    check_val("adel_exc", {27'd0, ExcCode_D}, 32'd4);
    check_val("adel_instr", instr_D, 32'h0);
    idle(); eret = 1; epc = 32'h3008; step();
    check_val("eret_pc", PC, 32'h3008);
    check_val("eret_valid", {31'd0, valid_D}, 32'd0);
    idle(); step();

    // PC+4 wrap
    idle(); npc_sel = 2'd3; jr_target = 32'hffff_fffc; step();
    idle(); step();
    check_val("wrap_pc", PC, 32'h0);

    // Random stimulus, including resets mid-stall and mid-refill
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(31) != 0);
      exc_req       = ($urandom_range(15) == 0);
      eret          = ($urandom_range(15) == 0);
      stall         = ($urandom_range(3) == 0);
      npc_sel       = 2'($urandom_range(3));
      is_jump_D     = 1'($urandom_range(1));
      branch_target = $urandom;
      jump_target   = $urandom;
      jr_target     = $urandom;
      epc           = $urandom;
      instr_F       = $urandom;
      ExcCode_F     = ($urandom_range(3) == 0) ? 5'd4 : 5'd0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
